// File: rtl/amstrad_plus_pkg.sv
`default_nettype none
// ============================================================================
// Module : amstrad_plus_pkg
// Desc   : Types, unlock table and decode constants shared by the Plus ASIC path
// Rev    : 1.0  initial release
// ============================================================================
package amstrad_plus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_SEQ   = 2'd2,
        ST_FINAL = 2'd3
    } asic_state_e;

    // RMR2 field layout, also consumed by the memory mapper
    typedef struct packed {
        logic [2:0] tag;
        logic [1:0] page;
        logic [2:0] bank;
    } rmr2_t;

    localparam logic [2:0] RMR2_TAG   = 3'b101;
    localparam logic [7:0] RMR2_RESET = 8'hA0;

    localparam logic [3:0] UNLOCK_LEN  = 4'd15;
    localparam logic [7:0] UNLOCK_LAST = 8'hEE;

    // CRTC select: A[14]=0, A[9:8]=00.  Gate array: A[15:14]=01.
    localparam logic [15:0] CRTC_SEL_MASK  = 16'h4300;
    localparam logic [15:0] CRTC_SEL_MATCH = 16'h0000;
    localparam logic [15:0] GA_SEL_MASK    = 16'hC000;
    localparam logic [15:0] GA_SEL_MATCH   = 16'h4000;

    function automatic logic [7:0] unlock_byte(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'hFF;
            4'd2:    return 8'h77;
            4'd3:    return 8'hB3;
            4'd4:    return 8'h51;
            4'd5:    return 8'hA8;
            4'd6:    return 8'hD4;
            4'd7:    return 8'h62;
            4'd8:    return 8'h39;
            4'd9:    return 8'h9C;
            4'd10:   return 8'h46;
            4'd11:   return 8'h2B;
            4'd12:   return 8'h15;
            4'd13:   return 8'h8A;
            4'd14:   return 8'hCD;
            4'd15:   return UNLOCK_LAST;
            default: return 8'h00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/amstrad_asic_unlock.sv
`default_nettype none
// ============================================================================
// Module : amstrad_asic_unlock
// Desc   : Plus ASIC unlock-sequence detector and RMR2 register
// Rev    : 1.0  initial release
// ============================================================================
module amstrad_asic_unlock
    import amstrad_plus_pkg::*;
(
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        plus_mode,
    input  logic        gx4000_mode,
    input  logic        io_WR,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    output logic        asic_enabled,
    output logic [7:0]  rmr2,
    output logic [3:0]  seq_idx
);

    logic        r_old_wr;
    logic        r_prev_nz;
    logic [3:0]  r_idx;
    logic        r_asic_enabled;
    logic [7:0]  r_rmr2;
    asic_state_e r_state;

    asic_state_e w_state_nxt;
    logic [3:0]  w_idx_nxt;
    logic        w_active;
    logic        w_we;
    logic        w_crtc_sel;
    logic        w_ga_sel;
    logic        w_d_nz;
    logic        w_unlock;
    logic        w_fail;
    rmr2_t       w_d_fields;

    assign w_active   = plus_mode | gx4000_mode;
    assign w_we       = ~r_old_wr & io_WR;
    assign w_crtc_sel = w_we & ((A & CRTC_SEL_MASK) == CRTC_SEL_MATCH);
    assign w_ga_sel   = w_we & ((A & GA_SEL_MASK) == GA_SEL_MATCH);
    assign w_d_nz     = (D != 8'h00);
    assign w_d_fields = rmr2_t'(D);

    // The edge detector keeps tracking the strobe even while inactive
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_old_wr <= 1'b0;
        end else begin
            r_old_wr <= io_WR;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_prev_nz <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (!w_active) begin
                r_prev_nz <= 1'b0;
            end else if (w_crtc_sel) begin
                r_prev_nz <= w_d_nz;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_unlock    = 1'b0;
        w_fail      = 1'b0;
        if (!w_active) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
        end else if (w_crtc_sel) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_d_nz) begin
                        w_state_nxt = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!w_d_nz) begin
                        w_state_nxt = ST_SEQ;
                        w_idx_nxt   = 4'd1;
                    end
                end
                ST_SEQ: begin
                    if (D == unlock_byte(r_idx)) begin
                        w_idx_nxt = r_idx + 4'd1;
                        if (r_idx == UNLOCK_LEN - 4'd1) begin
                            w_state_nxt = ST_FINAL;
                        end
                    end else if (w_d_nz) begin
                        w_state_nxt = ST_SYNC;
                        w_idx_nxt   = 4'd0;
                    end else if (r_prev_nz) begin
                        // A zero right after a non-zero byte restarts the match
                        w_idx_nxt = 4'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = 4'd0;
                    end
                end
                ST_FINAL: begin
                    w_idx_nxt = 4'd0;
                    if (D == unlock_byte(UNLOCK_LEN)) begin
                        w_unlock    = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = w_d_nz ? ST_SYNC : ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        seq_idx = 4'd0;
        case (r_state)
            ST_SEQ:   seq_idx = r_idx;
            ST_FINAL: seq_idx = UNLOCK_LEN;
            default:  seq_idx = 4'd0;
        endcase
    end

    // crtc_sel and ga_sel are mutually exclusive, so no priority issue here
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_asic_enabled <= 1'b0;
            r_rmr2         <= RMR2_RESET;
        end else if (!w_active) begin
            r_asic_enabled <= 1'b0;
            r_rmr2         <= RMR2_RESET;
        end else if (w_unlock) begin
            r_asic_enabled <= 1'b1;
        end else if (w_fail) begin
            r_asic_enabled <= 1'b0;
            r_rmr2         <= RMR2_RESET;
        end else if (w_ga_sel && (w_d_fields.tag == RMR2_TAG) && r_asic_enabled) begin
            r_rmr2 <= D;
        end
    end

    assign asic_enabled = r_asic_enabled;
    assign rmr2         = r_rmr2;

endmodule
`default_nettype wire

// File: tb/tb_amstrad_asic_unlock.sv
`default_nettype none
// ============================================================================
// Module : tb_amstrad_asic_unlock
// Desc   : Directed plus randomized bench against a byte-stream reference model
// Rev    : 1.0  initial release
// ============================================================================
module tb_amstrad_asic_unlock;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        plus_mode;
    logic        gx4000_mode;
    logic        io_WR;
    logic [15:0] A;
    logic [7:0]  D;
    logic        asic_enabled;
    logic [7:0]  rmr2;
    logic [3:0]  seq_idx;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;

    logic [7:0] tbl [1:15] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39,
                               8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};

    // Model: m_pos = -1 idle, 0 synced on a non-zero byte, k>=1 expecting tbl[k]
    int         m_pos;
    bit         m_last_nz;
    bit         m_en;
    logic [7:0] m_rmr2;

    always #5 CLK = ~CLK;

    amstrad_asic_unlock dut (
        .CLK          (CLK),
        .reset_n      (reset_n),
        .plus_mode    (plus_mode),
        .gx4000_mode  (gx4000_mode),
        .io_WR        (io_WR),
        .A            (A),
        .D            (D),
        .asic_enabled (asic_enabled),
        .rmr2         (rmr2),
        .seq_idx      (seq_idx)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s (after write %0d): observed=%02h expected=%02h", tag, n_writes, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos     = -1;
        m_last_nz = 1'b0;
        m_en      = 1'b0;
        m_rmr2    = 8'hA0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        bit crtc, ga;
        crtc = (a[14] == 1'b0) && (a[9:8] == 2'b00);
        ga   = (a[15:14] == 2'b01);
        if (!(plus_mode || gx4000_mode)) return;
        if (crtc) begin
            if (m_pos >= 1 && d == tbl[m_pos]) begin
                if (m_pos == 15) begin
                    m_en  = 1'b1;
                    m_pos = -1;
                end else begin
                    m_pos++;
                end
            end else begin
                if (m_pos == 15) begin
                    m_en   = 1'b0;
                    m_rmr2 = 8'hA0;
                end
                if (d != 8'h00)                                  m_pos = 0;
                else if (m_pos >= 0 && m_pos <= 14 && m_last_nz) m_pos = 1;
                else                                             m_pos = -1;
            end
            m_last_nz = (d != 8'h00);
        end else if (ga && d[7:5] == 3'b101 && m_en) begin
            m_rmr2 = d;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] e_idx;
        e_idx = (m_pos >= 1) ? 4'(m_pos) : 4'd0;
        check("seq_idx", {4'd0, seq_idx}, {4'd0, e_idx});
        check("asic_enabled", {7'd0, asic_enabled}, {7'd0, m_en});
        check("rmr2", rmr2, m_rmr2);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
        @(negedge CLK);
        A     = a;
        D     = d;
        io_WR = 1'b1;
        repeat (hold) @(negedge CLK);
        io_WR = 1'b0;
        n_writes++;
        model_write(a, d);
        check_outputs();
    endtask

    task automatic crtc(input logic [7:0] d);
        do_write(16'hBC00, d, 1);
    endtask

    task automatic send_sequence(input logic [7:0] last, input int hold);
        do_write(16'hBC00, 8'hFF, hold);
        do_write(16'hBC00, 8'h00, hold);
        for (int i = 1; i <= 14; i++) do_write(16'hBC00, tbl[i], hold);
        do_write(16'hBC00, last, hold);
    endtask

    task automatic set_mode(input logic p, input logic g);
        @(negedge CLK);
        plus_mode   = p;
        gx4000_mode = g;
        @(negedge CLK);
        if (!(p || g)) model_reset();
        check_outputs();
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;
        int          r;

        reset_n     = 1'b0;
        io_WR       = 1'b0;
        plus_mode   = 1'b1;
        gx4000_mode = 1'b0;
        A           = 16'h0000;
        D           = 8'h00;
        model_reset();
        repeat (3) @(negedge CLK);
        check_outputs();
        reset_n = 1'b1;

        // Full unlock
        send_sequence(8'hEE, 1);
        check("unlock_full", {7'd0, asic_enabled}, 8'h01);

        // RMR2 while unlocked
        do_write(16'h7F00, 8'hBB, 1);
        check("rmr2_bb", rmr2, 8'hBB);
        do_write(16'h7F00, 8'hC4, 1);
        check("rmr2_c4_ignored", rmr2, 8'hBB);

        // Wrong final byte relocks and resets RMR2
        send_sequence(8'h00, 1);
        check("wrong_final_en", {7'd0, asic_enabled}, 8'h00);
        check("wrong_final_rmr2", rmr2, 8'hA0);
        do_write(16'h7F00, 8'hB9, 1);
        check("rmr2_locked", rmr2, 8'hA0);

        // Resync mid-sequence
        crtc(8'hFF); crtc(8'h00); crtc(8'hFF); crtc(8'h77); crtc(8'hB3);
        crtc(8'h05);
        check("resync_idx", {4'd0, seq_idx}, 8'h00);
        crtc(8'h00);
        for (int i = 1; i <= 15; i++) crtc(tbl[i]);
        check("resync_unlock", {7'd0, asic_enabled}, 8'h01);

        // Held strobe consumes one byte
        crtc(8'hFF); crtc(8'h00);
        do_write(16'hBC00, 8'hFF, 5);
        check("hold_idx", {4'd0, seq_idx}, 8'h02);
        for (int i = 2; i <= 15; i++) do_write(16'hBC00, tbl[i], 5);

        // Active falls mid-sequence
        do_write(16'h7F00, 8'hBD, 1);
        crtc(8'hFF); crtc(8'h00); crtc(8'hFF); crtc(8'h77);
        set_mode(1'b0, 1'b0);
        check("inactive_idx", {4'd0, seq_idx}, 8'h00);
        check("inactive_rmr2", rmr2, 8'hA0);
        send_sequence(8'hEE, 1);
        check("inactive_no_unlock", {7'd0, asic_enabled}, 8'h00);

        // GX4000 alone enables the detector
        set_mode(1'b0, 1'b1);
        send_sequence(8'hEE, 1);
        check("gx_unlock", {7'd0, asic_enabled}, 8'h01);
        do_write(16'h7F00, 8'hB5, 1);

        // Asynchronous reset at idx 8
        crtc(8'hFF); crtc(8'h00);
        for (int i = 1; i <= 7; i++) crtc(tbl[i]);
        check("pre_reset_idx", {4'd0, seq_idx}, 8'h08);
        @(negedge CLK);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("async_rmr2", rmr2, 8'hA0);
        @(negedge CLK);
        reset_n = 1'b1;

        // Randomized attempts with corruption, noise writes and mode changes
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                r = $urandom_range(0, 3);
                set_mode(r[0], r[1]);
            end
            for (int k = 0; k < 17; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    r = $urandom_range(0, 2);
                    if (r != 0) begin
                        a = (16'($urandom) & 16'h3FFF) | 16'h4000;
                        d = ($urandom_range(0, 1) == 1) ? {3'b101, 5'($urandom)} : 8'($urandom);
                    end else begin
                        a = 16'($urandom) | 16'hC000;
                        d = 8'($urandom);
                    end
                    do_write(a, d, $urandom_range(1, 3));
                end
                d = (k == 0) ? 8'hFF : (k == 1) ? 8'h00 : tbl[k - 1];
                if ($urandom_range(0, 11) == 0) begin
                    d = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom);
                end
                a = 16'($urandom) & 16'hBCFF;
                do_write(a, d, $urandom_range(1, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
